zombie_queue: RTL and testbench
===============================

Name: zombie_queue

Overview:
- Zombie queue stage directly downstream of the hit detector. Holds the upcoming zombie lanes and drives the MD1/MD2/MD3 lane-enable lines that the detector compares against the buttons.
- Consumes the detector's shift and need_random pulses: pops the zombie that was hit and appends a pseudo-random new one.
- Also exports the full queue for the LED display and a saturating hit score.

Parameters:
- DEPTH, 4, number of queue slots; slot 0 is the head. Legal range 2..8.
- LFSR_W, 8, LFSR width; fixed taps x^8+x^6+x^5+x^4+1, so only 8 is legal.
- SEED, 8'hA5, LFSR reset value; a SEED of 0 is replaced by 8'h01.
- SCORE_W, 8, score counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0); deassertion is synchronised externally.
- shift  in  1  one-cycle pulse from the detector: the head zombie was hit, pop the head.
- need_random  in  1  one-cycle pulse from the detector: push a new random lane at the tail.
- MD1  out  1  head zombie is in lane 0.
- MD2  out  1  head zombie is in lane 1.
- MD3  out  1  head zombie is in lane 2.
- queue_lanes  out  2*DEPTH  slot i occupies bits [2i+1:2i]; 2'd3 means an empty slot.
- count  out  4  number of occupied slots, 0..DEPTH.
- ready  out  1  1 once the initial fill is complete.
- score  out  SCORE_W  number of pops, saturating at all-ones.

Behaviour:
- Reset (rst=0):
  - FSM in FILL, all slots 2'd3, count=0.
  - MD1..MD3=0, ready=0, score=0, lfsr=SEED.
- LFSR:
  - Fibonacci, advances every clock in every state: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Free-running, so each new lane depends on player timing.
- Lane derivation from the current lfsr value: if lfsr[1:0] != 3, lane = lfsr[1:0]; otherwise lane = {1'b0, lfsr[2]}. A lane value of 3 is never produced.
- FILL state:
  - One lane pushed per clock at the first empty slot.
  - After DEPTH pushes, transition to RUN and set ready=1 on the same edge.
  - shift and need_random are ignored in FILL.
- RUN state, events sampled each edge:
  - shift & need_random: slots shift toward the head; the tail takes the new lane; count unchanged; score++.
  - shift only: slots shift; the tail becomes 2'd3; count-- (no change if count=0); score++ only if count was >0.
  - need_random only: push into slot[count] if count<DEPTH; ignored when full.
  - Neither: hold.
- Head decode:
  - MD1..MD3 are registers, one-hot decode of the next slot 0 value; all zero if slot 0 is empty.
  - Latency: MD updates on the same edge that samples shift, i.e. visible 1 cycle after the pulse.
- Score saturates at 2^SCORE_W-1 and never wraps.
- An asynchronous reset mid-operation returns immediately to the reset values, and FILL restarts from SEED.
- No combinational path from any input to any output.

Decomposition:
- Package zq_pkg holds:
  - the lane typedef (2 bits);
  - LANE_EMPTY=2'd3;
  - the FILL/RUN state encoding;
  - the LFSR tap mask.
- One sub-module, zq_lfsr: free-running LFSR plus lane derivation. Outputs lane[1:0]; parameter SEED.
- The queue register array, count, FSM, MD decode and score stay in zombie_queue.

Test Plan:
- Reset then release, SEED=A5, DEPTH=4: LFSR values A5, 4A, 95, 2A are used at edges 1-4. Queue head→tail is 1,2,1,2 and count=4. ready=1 and MD2=1 after edge 4. MD1..MD3=0 during edges 1-3.
- shift+need_random pulsed in the first RUN cycle (lfsr=54, lane 0): queue becomes 2,1,2,0, MD3=1, score=1, count=4.
- Four shift-only pulses from full: count steps 3,2,1,0. After the last pulse MD1..MD3=0 and queue_lanes is all ones. A fifth shift leaves score and count unchanged.
- need_random only while full: queue, count and MD are unchanged. need_random while count=2: the new lane lands in slot 2 and count=3.
- Score saturation with SCORE_W=2: five hits give score 1,2,3,3,3.
- rst pulled low mid-RUN with a pulse in the same cycle: all outputs return to their reset values immediately. After release, the FILL sequence exactly repeats the first scenario.

Source files
------------

// File: rtl/zq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zq_pkg
// Description : Shared types and constants for the zombie queue stage.
// Revision    : 1.0 - initial release
// ============================================================================
package zq_pkg;

  // One zombie lane; 0..2 are real lanes, 3 marks an empty slot.
  typedef logic [1:0] lane_t;

  localparam lane_t LANE_EMPTY = 2'd3;

  // Queue controller states.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Taps of x^8+x^6+x^5+x^4+1 as seen from a left-shifting register:
  // feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3].
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Map an LFSR value onto a lane that is never 3.
  function automatic lane_t lane_from_lfsr(input logic [7:0] value);
    if (value[1:0] != 2'd3) begin
      return value[1:0];
    end
    return {1'b0, value[2]};
  endfunction

endpackage : zq_pkg
`default_nettype wire

// File: rtl/zq_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : zq_lfsr
// Description : Free-running 8-bit Fibonacci LFSR plus lane derivation for
//               new zombies.
// Revision    : 1.0 - initial release
// ============================================================================
module zq_lfsr
  import zq_pkg::*;
#(
  parameter int              LFSR_W = 8,
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic  clk,
  input  logic  rst,
  output lane_t lane
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [LFSR_W-1:0] RESET_VALUE =
    (SEED == '0) ? LFSR_W'(1) : SEED;
  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  logic [LFSR_W-1:0] lfsr;
  logic              feedback;

  assign feedback = ^(lfsr & TAPS);
  assign lane     = lane_from_lfsr(8'(lfsr));

  // Advance every clock regardless of queue state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= RESET_VALUE;
    end else begin
      lfsr <= {lfsr[LFSR_W-2:0], feedback};
    end
  end

endmodule : zq_lfsr
`default_nettype wire

// File: rtl/zombie_queue.sv
`default_nettype none
// ============================================================================
// Module      : zombie_queue
// Description : Queue of upcoming zombie lanes downstream of the hit
//               detector. Drives the head lane-enable lines, pops on hits,
//               appends pseudo-random lanes, and keeps a saturating score.
// Revision    : 1.0 - initial release
// ============================================================================
module zombie_queue
  import zq_pkg::*;
#(
  parameter int                DEPTH   = 4,
  parameter int                LFSR_W  = 8,
  parameter logic [LFSR_W-1:0] SEED    = 8'hA5,
  parameter int                SCORE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift,
  input  logic                 need_random,
  output logic                 MD1,
  output logic                 MD2,
  output logic                 MD3,
  output logic [2*DEPTH-1:0]   queue_lanes,
  output logic [3:0]           count,
  output logic                 ready,
  output logic [SCORE_W-1:0]   score
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  state_t             state, state_next;
  lane_t              slots      [DEPTH];
  lane_t              slots_next [DEPTH];
  lane_t              new_lane;
  logic [3:0]         count_next;
  logic [SCORE_W-1:0] score_next;
  logic [2:0]         md, md_next;
  logic               hit;

  zq_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .lane (new_lane)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pack
    assign queue_lanes[2*gi+1:2*gi] = slots[gi];
  end

  assign {MD3, MD2, MD1} = md;
  assign ready           = (state == ST_RUN);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_FILL;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, queue update, score and head decode.
  always_comb begin
    state_next = state;
    slots_next = slots;
    count_next = count;
    score_next = score;
    hit        = 1'b0;
    md_next    = 3'b000;

    case (state)
      ST_FILL: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (i == int'(count)) begin
            slots_next[i] = new_lane;
          end
        end
        count_next = count + 4'd1;
        if (count_next == DEPTH_C) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (shift) begin
          for (int i = 0; i < DEPTH - 1; i++) begin
            slots_next[i] = slots[i+1];
          end
          slots_next[DEPTH-1] = need_random ? new_lane : LANE_EMPTY;
          if (need_random) begin
            hit = 1'b1;
          end else if (count != 4'd0) begin
            count_next = count - 4'd1;
            hit        = 1'b1;
          end
        end else if (need_random && (count < DEPTH_C)) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (i == int'(count)) begin
              slots_next[i] = new_lane;
            end
          end
          count_next = count + 4'd1;
        end
      end
      default: state_next = ST_FILL;
    endcase

    if (hit && (score != '1)) begin
      score_next = score + 1'b1;
    end

    // Lane enables only come alive once the queue is running.
    if (state_next == ST_RUN) begin
      case (slots_next[0])
        2'd0:    md_next = 3'b001;
        2'd1:    md_next = 3'b010;
        2'd2:    md_next = 3'b100;
        default: md_next = 3'b000;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= LANE_EMPTY;
      end
      count <= 4'd0;
      score <= '0;
      md    <= 3'b000;
    end else begin
      slots <= slots_next;
      count <= count_next;
      score <= score_next;
      md    <= md_next;
    end
  end

endmodule : zombie_queue
`default_nettype wire

// File: tb/tb_zombie_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_zombie_queue
// Description : Self-checking bench for zombie_queue with a queue-level
//               reference model and directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zombie_queue;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic shift = 1'b0;
  logic need_random = 1'b0;

  logic             md1, md2, md3;
  logic [2*DEPTH-1:0] queue_lanes;
  logic [3:0]       count;
  logic             ready;
  logic [7:0]       score;

  logic             s_md1, s_md2, s_md3;
  logic [2*DEPTH-1:0] s_queue_lanes;
  logic [3:0]       s_count;
  logic             s_ready;
  logic [1:0]       s_score;

  always #5 clk = ~clk;

  zombie_queue #(.DEPTH(DEPTH), .LFSR_W(8), .SEED(8'hA5), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .shift(shift), .need_random(need_random),
    .MD1(md1), .MD2(md2), .MD3(md3), .queue_lanes(queue_lanes),
    .count(count), .ready(ready), .score(score)
  );

  zombie_queue #(.DEPTH(DEPTH), .LFSR_W(8), .SEED(8'hA5), .SCORE_W(2)) dut_s2 (
    .clk(clk), .rst(rst), .shift(shift), .need_random(need_random),
    .MD1(s_md1), .MD2(s_md2), .MD3(s_md3), .queue_lanes(s_queue_lanes),
    .count(s_count), .ready(s_ready), .score(s_score)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit [7:0] m_lfsr   = 8'hA5;
  int       mq[$];
  int       m_count  = 0;
  bit       m_ready  = 0;
  int       m_score  = 0;
  int       m_score2 = 0;

  function automatic int lane_of(input bit [7:0] v);
    if (v[1:0] != 2'd3) return int'(v[1:0]);
    return int'(v[2]);
  endfunction

  function automatic bit [7:0] lfsr_step(input bit [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic void model_reset();
    m_lfsr = 8'hA5;
    mq = {};
    for (int i = 0; i < DEPTH; i++) mq.push_back(3);
    m_count = 0; m_ready = 0; m_score = 0; m_score2 = 0;
  endfunction

  function automatic void model_hit();
    if (m_score < 255) m_score++;
    if (m_score2 < 3) m_score2++;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      int lane;
      lane = lane_of(m_lfsr);
      if (!m_ready) begin
        mq[m_count] = lane;
        m_count++;
        if (m_count == DEPTH) m_ready = 1;
      end else if (shift && need_random) begin
        void'(mq.pop_front());
        mq.push_back(lane);
        model_hit();
      end else if (shift) begin
        void'(mq.pop_front());
        mq.push_back(3);
        if (m_count > 0) begin
          m_count--;
          model_hit();
        end
      end else if (need_random && m_count < DEPTH) begin
        mq[m_count] = lane;
        m_count++;
      end
      m_lfsr = lfsr_step(m_lfsr);
    end
  end

  function automatic logic [2*DEPTH-1:0] exp_lanes();
    logic [2*DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) v[2*i +: 2] = 2'(mq[i]);
    return v;
  endfunction

  function automatic logic [2:0] exp_md();
    if (!m_ready || mq[0] == 3) return 3'b000;
    return 3'(1 << mq[0]);
  endfunction

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (mq.size() == DEPTH) begin
      check("lanes", 32'(queue_lanes), 32'(exp_lanes()));
      check("count", 32'(count), 32'(m_count));
      check("ready", 32'(ready), 32'(m_ready));
      check("score", 32'(score), 32'(m_score));
      check("md",    32'({md3, md2, md1}), 32'(exp_md()));
      check("score_sat2", 32'(s_score), 32'(m_score2));
      check("lanes_s2", 32'(s_queue_lanes), 32'(exp_lanes()));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse(input bit s, input bit n);
    shift = s;
    need_random = n;
    @(negedge clk);
    shift = 1'b0;
    need_random = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_lanes"}, 32'(queue_lanes), 32'hFF);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_ready"}, 32'(ready), 32'd0);
    check({tag, "_score"}, 32'(score), 32'd0);
    check({tag, "_md"}, 32'({md3, md2, md1}), 32'd0);
    check({tag, "_score2"}, 32'(s_score), 32'd0);
  endtask

  task automatic run_fill(input string tag);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      check({tag, "_fill_md"}, 32'({md3, md2, md1}), 32'd0);
      check({tag, "_fill_ready"}, 32'(ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_full_lanes"}, 32'(queue_lanes), 32'h99);
    check({tag, "_full_count"}, 32'(count), 32'd4);
    check({tag, "_full_ready"}, 32'(ready), 32'd1);
    check({tag, "_full_md"}, 32'({md3, md2, md1}), 32'b010);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b1;
    run_fill("first");

    // First RUN cycle: hit plus refill with lfsr=54 -> lane 0.
    pulse(1'b1, 1'b1);
    check("hit_lanes", 32'(queue_lanes), 32'h26);
    check("hit_md", 32'({md3, md2, md1}), 32'b100);
    check("hit_score", 32'(score), 32'd1);
    check("hit_count", 32'(count), 32'd4);

    // Drain with shift-only pulses.
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b0);
      check("drain_count", 32'(count), 32'(3 - k));
    end
    check("empty_lanes", 32'(queue_lanes), 32'hFF);
    check("empty_md", 32'({md3, md2, md1}), 32'd0);
    check("empty_score", 32'(score), 32'd5);
    check("sat_score2", 32'(s_score), 32'd3);

    // Shift while empty: no score, no count change.
    pulse(1'b1, 1'b0);
    check("idle_shift_count", 32'(count), 32'd0);
    check("idle_shift_score", 32'(score), 32'd5);
    check("idle_shift_score2", 32'(s_score), 32'd3);

    // Refill with need_random only.
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    check("push_count2", 32'(count), 32'd2);
    pulse(1'b0, 1'b1);
    check("push_count3", 32'(count), 32'd3);
    check("push_slot2_valid", 32'(queue_lanes[5:4] != 2'd3), 32'd1);
    pulse(1'b0, 1'b1);
    check("push_count4", 32'(count), 32'd4);
    pulse(1'b0, 1'b1);
    check("push_full_count", 32'(count), 32'd4);
    check("push_full_score", 32'(score), 32'd5);

    // Async reset in the middle of a shift cycle.
    shift = 1'b1;
    #2 rst = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    shift = 1'b0;
    check_reset_values("midrst_held");
    @(negedge clk);
    rst = 1'b1;
    run_fill("second");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_zombie_queue
`default_nettype wire
